// File: rtl/ram_rw_sequencer.sv
// ram_rw_sequencer: self-test initiator for a single-port synchronous RAM.
//
// Runs a full-address write pass with a seeded pattern (pattern(a) = a ^ SEED).
// It then runs a full read-back pass and compares each returned word on chip.
// When the sequence ends it reports done, pass, a saturating error count and
// the first failing address.
//
// Optional build macro RW_INVERT_PASS_EN adds a second write/read pass that
// uses the inverted pattern. Errors accumulate across both passes.
//
// Ports:
//   clk            rising-edge clock
//   async_rst      asynchronous active-low reset
//   start          single-cycle run request; only sampled in IDLE or DONE
//   addr/data/we/clken  RAM request (all registered)
//   qout           RAM read data, valid READ_LATENCY cycles after a read issue
//   busy           high from the first access until DONE is entered
//   done, pass     completion status; pass valid while done=1
//   err_count      mismatch count, saturates at all-ones
//   first_err_addr address of the first mismatch of a run (0 if none)
module ram_rw_sequencer #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(8'h5A),
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     async_rst,
  input  logic                     start,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [DATA_WIDTH-1:0]    data,
  output logic                     we,
  output logic                     clken,
  input  logic [DATA_WIDTH-1:0]    qout,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [ADDR_WIDTH-1:0]    first_err_addr
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
`ifdef RW_INVERT_PASS_EN
    StWrite2,
    StRead2,
`endif
    StDrain,
    StDone
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] AddrMax = {ADDR_WIDTH{1'b1}};
  localparam logic [ERR_CNT_WIDTH-1:0] ErrMax = {ERR_CNT_WIDTH{1'b1}};
  localparam logic [2:0] DrainLast = 3'(READ_LATENCY - 1);

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    return DATA_WIDTH'(a) ^ SEED;
  endfunction

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     we_q, we_d;
  logic                     clken_q, clken_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
  logic [ADDR_WIDTH-1:0]    ferr_q, ferr_d;
  logic [2:0]               drain_q, drain_d;

  // Compare pipeline. Stage 0 is loaded with the read currently on the RAM
  // port, so stage READ_LATENCY-1 lines up with its qout.
  logic                  pv_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pa_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd_q [READ_LATENCY];

  logic                  rd_inv;
  logic                  issue_rd;
  logic [DATA_WIDTH-1:0] issue_exp;

`ifdef RW_INVERT_PASS_EN
  assign rd_inv = (state_q == StRead2);
`else
  assign rd_inv = 1'b0;
`endif

  assign issue_rd  = clken_q & ~we_q;
  assign issue_exp = rd_inv ? ~pattern(addr_q) : pattern(addr_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    clken_d = clken_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    drain_d = drain_q;

    // Matured read: err_q==0 marks the first mismatch because the counter
    // only increases within a run.
    if (pv_q[READ_LATENCY-1] && (qout != pd_q[READ_LATENCY-1])) begin
      if (err_q != ErrMax) err_d = err_q + ERR_CNT_WIDTH'(1);
      if (err_q == '0)     ferr_d = pa_q[READ_LATENCY-1];
    end

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWrite;
          addr_d  = '0;
          data_d  = pattern('0);
          we_d    = 1'b1;
          clken_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          ferr_d  = '0;
        end
      end
      StWrite: begin
        if (addr_q == AddrMax) begin
          state_d = StRead;
          addr_d  = '0;
          data_d  = '0;
          we_d    = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          data_d = pattern(addr_q + ADDR_WIDTH'(1));
        end
      end
      StRead: begin
        if (addr_q == AddrMax) begin
`ifdef RW_INVERT_PASS_EN
          // No drain here: pass-1 reads retire while WRITE2 issues.
          state_d = StWrite2;
          addr_d  = '0;
          data_d  = ~pattern('0);
          we_d    = 1'b1;
`else
          state_d = StDrain;
          clken_d = 1'b0;
          drain_d = '0;
`endif
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
`ifdef RW_INVERT_PASS_EN
      StWrite2: begin
        if (addr_q == AddrMax) begin
          state_d = StRead2;
          addr_d  = '0;
          data_d  = '0;
          we_d    = 1'b0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          data_d = ~pattern(addr_q + ADDR_WIDTH'(1));
        end
      end
      StRead2: begin
        if (addr_q == AddrMax) begin
          state_d = StDrain;
          clken_d = 1'b0;
          drain_d = '0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
`endif
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses err_d so the compare retiring on this edge is included.
          pass_d  = (err_d == '0);
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      clken_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ferr_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      clken_q <= clken_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= issue_rd;
      pa_q[0] <= addr_q;
      pd_q[0] <= issue_exp;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign addr           = addr_q;
  assign data           = data_q;
  assign we             = we_q;
  assign clken          = clken_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

endmodule
